// File: rtl/seq_pattern_generator.sv
// rtl/seq_pattern_generator.sv - MSB-first serial bit-pattern generator; define SEQGEN_LOOP_COUNT_EN to add loop_cnt
module seq_pattern_generator #(
  parameter int                 MAX_LEN       = 16,
  parameter int                 LEN_W         = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(4'b1011),
  parameter int                 RESET_LEN     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_loop,
  input  logic               ready,
  output logic               data_out,
  output logic               valid,
  output logic               busy,
  output logic               done,
`ifdef SEQGEN_LOOP_COUNT_EN
  output logic [15:0]        loop_cnt,
`endif
  output logic               cfg_err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic               r_loop;
  logic               r_data;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;

  logic               w_len_ok;
  logic               w_load_ok;
  logic [MAX_LEN-1:0] w_pat_eff;
  logic [LEN_W-1:0]   w_len_eff;
  logic [LEN_W-1:0]   w_len_eff_m1;
  logic [LEN_W-1:0]   w_idx_m1;
  logic               w_first_bit;
  logic               w_next_bit;
  logic               w_xfer;
  logic               w_run_start;

  // A load is only honoured in IDLE and with a length in 1..MAX_LEN.
  assign w_len_ok  = (len_in != '0) && (len_in <= LEN_W'(MAX_LEN));
  assign w_load_ok = load && w_len_ok && (r_state == S_IDLE);

  // Effective pattern/length: a same-cycle legal load is seen by a same-cycle start.
  assign w_pat_eff    = w_load_ok ? pattern_in : r_pat;
  assign w_len_eff    = w_load_ok ? len_in : r_len;
  assign w_len_eff_m1 = w_len_eff - LEN_W'(1);
  assign w_idx_m1     = r_idx - LEN_W'(1);

  // Bit selection by shift keeps the index width independent of MAX_LEN.
  assign w_first_bit = 1'(w_pat_eff >> w_len_eff_m1);
  assign w_next_bit  = 1'(r_pat >> w_idx_m1);

  assign w_xfer      = r_valid && ready;
  assign w_run_start = (r_state == S_IDLE) && start && !stop;

  // Two-state generator FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pat     <= RESET_PATTERN;
      r_len     <= LEN_W'(RESET_LEN);
      r_idx     <= '0;
      r_loop    <= 1'b0;
      r_data    <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_pat     <= w_pat_eff;
      r_len     <= w_len_eff;
      case (r_state)
        S_IDLE: begin
          r_cfg_err <= load && !w_len_ok;
          if (w_run_start) begin
            r_state <= S_RUN;
            r_idx   <= w_len_eff_m1;
            r_loop  <= mode_loop;
            r_data  <= w_first_bit;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_cfg_err <= load;
          if (stop) begin
            r_state <= S_IDLE;
            r_data  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (r_idx != '0) begin
              r_idx  <= w_idx_m1;
              r_data <= w_next_bit;
            end else if (r_loop) begin
              r_idx  <= w_len_eff_m1;
              r_data <= w_first_bit;
            end else begin
              r_state <= S_IDLE;
              r_data  <= 1'b0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;

`ifdef SEQGEN_LOOP_COUNT_EN
  logic [15:0] r_loop_cnt;
  logic        w_pass_done;

  // A pass completes when the bit at index 0 is accepted and no stop aborts it.
  assign w_pass_done = (r_state == S_RUN) && !stop && w_xfer && (r_idx == '0);

  // Completed-pass counter: cleared by a start, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_loop_cnt <= '0;
    end else if (w_run_start) begin
      r_loop_cnt <= '0;
    end else if (w_pass_done && (r_loop_cnt != 16'hFFFF)) begin
      r_loop_cnt <= r_loop_cnt + 16'd1;
    end
  end

  assign loop_cnt = r_loop_cnt;
`endif

endmodule
